// File: rtl/io_port_pkg.sv
// io_port_pkg: shared definitions for the memory-mapped I/O port responder.
//   - Register offsets within the 16-byte window
//   - Bit positions inside STATUS and CTRL
//   - Bus-response FSM state encoding
package io_port_pkg;

    localparam logic [3:0] OFF_OUT    = 4'h0;
    localparam logic [3:0] OFF_IN     = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'hC;

    localparam int unsigned STATUS_IN_CHANGED_BIT = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT       = 0;

    typedef enum logic [0:0] {
        IDLE,
        RESP
    } stateT;

endpackage

// File: rtl/input_sync_detect.sv
// input_sync_detect: brings an asynchronous input bus into the clock domain and
// flags any change in its synchronized value.
//   clk      system clock
//   reset    synchronous, active-high reset
//   portIn   asynchronous input pins
//   syncVal  synchronized input (second synchronizer stage)
//   changed  high while syncVal differs from its value one cycle earlier
module input_sync_detect #(
    parameter int unsigned IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] portIn,
    output logic [IN_WIDTH-1:0] syncVal,
    output logic                changed
);

    logic [IN_WIDTH-1:0] sync1;
    logic [IN_WIDTH-1:0] sync2;
    logic [IN_WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= portIn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign syncVal = sync2;
    assign changed = (sync2 != prev);

endmodule

// File: rtl/io_port_responder.sv
// io_port_responder: bus target for the 16-byte I/O window at BASE_ADDR.
//   Register map: 0x0 OUT (rw), 0x4 IN (ro), 0x8 STATUS (bit0 sticky change flag,
//   clear-on-read), 0xC CTRL (bit0 irq enable).
//   clk       system clock
//   reset     synchronous, active-high reset
//   req/we/addr/wdata   bus request, accepted in IDLE
//   ack/err/rdata       one-cycle response, the cycle after accept
//   port_in   asynchronous input pins
//   port_out  output port register
//   irq       registered (in_changed & irq_en)
module io_port_responder
    import io_port_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IN_WIDTH   = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ack,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic [IN_WIDTH-1:0]   port_in,
    output logic [DATA_WIDTH-1:0] port_out,
    output logic                  irq
);

    stateT                 state;
    logic                  ackReg;
    logic                  errReg;
    logic [DATA_WIDTH-1:0] rdataReg;
    logic [DATA_WIDTH-1:0] portOutReg;
    logic                  irqEn;
    logic                  inChanged;
    logic                  irqReg;

    logic [IN_WIDTH-1:0]   syncVal;
    logic                  changed;

    logic [3:0]            offset;
    logic                  addrOk;
    logic                  accept;
    logic                  statusClear;
    logic [DATA_WIDTH-1:0] readValue;

    input_sync_detect #(
        .IN_WIDTH(IN_WIDTH)
    ) uSync (
        .clk    (clk),
        .reset  (reset),
        .portIn (port_in),
        .syncVal(syncVal),
        .changed(changed)
    );

    always_comb begin
        offset      = addr[3:0];
        addrOk      = (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);
        accept      = (state == IDLE) && req;
        statusClear = accept && addrOk && !we && (offset == OFF_STATUS);

        readValue = '0;
        case (offset)
            OFF_OUT:    readValue = portOutReg;
            OFF_IN:     readValue = {{(DATA_WIDTH-IN_WIDTH){1'b0}}, syncVal};
            OFF_STATUS: readValue[STATUS_IN_CHANGED_BIT] = inChanged;
            OFF_CTRL:   readValue[CTRL_IRQ_EN_BIT] = irqEn;
            default:    readValue = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ackReg     <= 1'b0;
            errReg     <= 1'b0;
            rdataReg   <= '0;
            portOutReg <= '0;
            irqEn      <= 1'b0;
            inChanged  <= 1'b0;
            irqReg     <= 1'b0;
        end else begin
            irqReg <= inChanged & irqEn;

            // A detection on the clearing edge wins over the clear.
            if (changed) begin
                inChanged <= 1'b1;
            end else if (statusClear) begin
                inChanged <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        state    <= RESP;
                        ackReg   <= 1'b1;
                        errReg   <= !addrOk;
                        rdataReg <= (addrOk && !we) ? readValue : '0;
                        if (addrOk && we) begin
                            if (offset == OFF_OUT) begin
                                portOutReg <= wdata;
                            end
                            if (offset == OFF_CTRL) begin
                                irqEn <= wdata[CTRL_IRQ_EN_BIT];
                            end
                        end
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    ackReg   <= 1'b0;
                    errReg   <= 1'b0;
                    rdataReg <= '0;
                end
                default: begin
                    state  <= IDLE;
                    ackReg <= 1'b0;
                end
            endcase
        end
    end

    // Reset during RESP must suppress the pending response within that cycle,
    // so the response outputs are masked by reset rather than waiting an edge.
    assign ack      = ackReg && !reset;
    assign err      = errReg && !reset;
    assign rdata    = reset ? '0 : rdataReg;
    assign port_out = portOutReg;
    assign irq      = irqReg;

endmodule

// File: tb/tb_io_port_responder.sv
module tb_io_port_responder;

    localparam logic [31:0] BASE   = 32'h1001_0000;
    localparam logic [31:0] A_OUT  = BASE + 32'h0;
    localparam logic [31:0] A_IN   = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_CTRL = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  port_in = '0;
    logic [31:0] port_out;
    logic        irq;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } expT;

    expT         expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ackCyclePortOut;

    io_port_responder dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .ack     (ack),
        .err     (err),
        .rdata   (rdata),
        .port_in (port_in),
        .port_out(port_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected response whenever the DUT acks.
    always @(negedge clk) begin
        if (ack) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=1 expected no response at %0t", $time);
            end else begin
                expT e;
                e = expQ.pop_front();
                check("resp_err", {31'b0, err}, {31'b0, e.err});
                check("resp_rdata", rdata, e.data);
            end
        end else begin
            check("idle_rdata_err", {err, rdata[30:0]} | {1'b0, rdata[31], 30'b0}, 32'h0);
        end
    end

    // Starts and ends at #1 after a posedge with the FSM in IDLE.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic eErr, input logic [31:0] eData);
        expQ.push_back('{err: eErr, data: eData});
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        ackCyclePortOut = port_out;
        @(posedge clk); #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        check("rst_port_out", port_out, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        reset = 1'b0;
        cyc(1);
        xfer(1'b0, A_OUT,  '0, 1'b0, 32'h0);
        xfer(1'b0, A_CTRL, '0, 1'b0, 32'h0);
        xfer(1'b0, A_STAT, '0, 1'b0, 32'h0);

        // Write then read OUT
        xfer(1'b1, A_OUT, 32'hDEAD_BEEF, 1'b0, 32'h0);
        check("out_in_ack_cycle", ackCyclePortOut, 32'hDEAD_BEEF);
        xfer(1'b0, A_OUT, '0, 1'b0, 32'hDEAD_BEEF);

        // Input change and clear-on-read
        port_in = 8'hA5;
        cyc(3);
        xfer(1'b0, A_IN,   '0, 1'b0, 32'h0000_00A5);
        xfer(1'b0, A_STAT, '0, 1'b0, 32'h1);
        xfer(1'b0, A_STAT, '0, 1'b0, 32'h0);

        // Interrupt
        xfer(1'b1, A_CTRL, 32'h1, 1'b0, 32'h0);
        xfer(1'b0, A_CTRL, '0, 1'b0, 32'h1);
        port_in = 8'h3C;
        cyc(3);
        check("irq_before", {31'b0, irq}, 32'h0);
        cyc(1);
        check("irq_set", {31'b0, irq}, 32'h1);
        xfer(1'b0, A_STAT, '0, 1'b0, 32'h1);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        xfer(1'b1, A_CTRL, 32'h0, 1'b0, 32'h0);

        // Decode errors with the flag set
        port_in = 8'h11;
        cyc(3);
        xfer(1'b1, BASE + 32'h10, 32'h1234, 1'b1, 32'h0);
        check("err_out_kept", port_out, 32'hDEAD_BEEF);
        xfer(1'b0, BASE + 32'h2,  '0, 1'b1, 32'h0);
        xfer(1'b0, BASE + 32'h18, '0, 1'b1, 32'h0);
        xfer(1'b1, 32'h1000_000C, 32'h1, 1'b1, 32'h0);
        xfer(1'b1, A_IN, 32'hFF, 1'b0, 32'h0);
        xfer(1'b0, A_IN,   '0, 1'b0, 32'h11);
        xfer(1'b0, A_CTRL, '0, 1'b0, 32'h0);
        xfer(1'b0, A_STAT, '0, 1'b0, 32'h1);
        xfer(1'b0, A_STAT, '0, 1'b0, 32'h0);

        // Set/clear collision: detection lands on the read's accept edge
        port_in = 8'h22;
        cyc(2);
        xfer(1'b0, A_STAT, '0, 1'b0, 32'h0);
        xfer(1'b0, A_STAT, '0, 1'b0, 32'h1);
        xfer(1'b0, A_STAT, '0, 1'b0, 32'h0);

        // Held req for 6 cycles: accepts on edges 1, 3, 5
        for (int i = 0; i < 3; i++) expQ.push_back('{err: 1'b0, data: 32'hDEAD_BEEF});
        req  = 1'b1;
        we   = 1'b0;
        addr = A_OUT;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("held_ack", {31'b0, ack}, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        req = 1'b0;
        cyc(1);

        // Reset during RESP
        port_in = 8'h00;
        req   = 1'b1;
        we    = 1'b1;
        addr  = A_OUT;
        wdata = 32'h5;
        @(posedge clk); #1;
        req = 1'b0;
        check("rst_mid_applied", port_out, 32'h5);
        reset = 1'b1;
        #1;
        check("rst_mid_ack_now", {31'b0, ack}, 32'h0);
        @(posedge clk); #1;
        check("rst_mid_ack_next", {31'b0, ack}, 32'h0);
        check("rst_mid_port_out", port_out, 32'h0);
        check("rst_mid_irq", {31'b0, irq}, 32'h0);
        check("rst_mid_err", {31'b0, err}, 32'h0);
        check("rst_mid_rdata", rdata, 32'h0);
        reset = 1'b0;
        cyc(1);
        check("rst_mid_ack_after", {31'b0, ack}, 32'h0);
        xfer(1'b0, A_OUT,  '0, 1'b0, 32'h0);
        xfer(1'b0, A_STAT, '0, 1'b0, 32'h0);
        xfer(1'b0, A_CTRL, '0, 1'b0, 32'h0);

        cyc(2);
        check("pending_responses", expQ.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
